// File: rtl/score_seven_seg_driver.sv
// Sequential binary-to-BCD (shift-add-3, saturating at 9999) feeding a 4-digit
// common-anode seven-segment multiplexer. Optional macro: LEADING_ZERO_BLANK_EN.
module score_seven_seg_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] val,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [15:0] bcd,
  output logic        ovf
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t         r_state;
  logic [13:0]    r_shift;
  logic [15:0]    r_work;
  logic [3:0]     r_cnt;
  logic           r_ovf_pend;
  logic [CW-1:0]  r_ref;
  logic [1:0]     r_sel;

  logic [15:0]    w_adj;
  logic [29:0]    w_next;
  logic [3:0]     w_nib;
  logic           w_blank;
  logic [6:0]     w_seg;

  function automatic logic [15:0] add3(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    for (int i = 0; i < 4; i++)
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_adj  = add3(r_work);
  assign w_next = {w_adj, r_shift} << 1;
  assign w_nib  = bcd[4*r_sel +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and everything above it are zero; ones never blanks.
  assign w_blank = (r_sel != 2'd0) && ((bcd >> {r_sel, 2'b00}) == 16'h0000);
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg = w_blank ? 7'b1111111 : encode(w_nib);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_shift    <= (val > 32'd9999) ? 14'd9999 : val[13:0];
          r_ovf_pend <= (val > 32'd9999);
          r_work     <= '0;
          r_cnt      <= '0;
          r_state    <= CONVERT;
        end
        CONVERT: begin
          {r_work, r_shift} <= w_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd13) r_state <= LOAD;
        end
        LOAD: begin
          bcd     <= r_work;
          ovf     <= r_ovf_pend;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= '0;
      r_sel <= '0;
      seg   <= 7'b1111111;
      an    <= 4'b1111;
      dp    <= 1'b1;
    end else begin
      if (r_ref == CW'(REFRESH_DIV - 1)) begin
        r_ref <= '0;
        r_sel <= r_sel + 2'd1;
      end else begin
        r_ref <= r_ref + 1'b1;
      end
      an  <= ~(4'b0001 << r_sel);
      seg <= w_seg;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_seven_seg_driver.sv
// Bench for score_seven_seg_driver: directed steps then random values, compared
// each cycle against a decimal-arithmetic reference of the display.
module tb_score_seven_seg_driver;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] val;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [15:0] bcd;
  logic        ovf;

  score_seven_seg_driver #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .val(val), .seg(seg), .an(an),
    .dp(dp), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          k;
  logic [31:0] cap;
  logic [15:0] m_bcd;
  logic        m_ovf;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  logic [6:0]  tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

  function automatic logic [15:0] to_bcd(input logic [31:0] v);
    int s;
    s = (v > 32'd9999) ? 9999 : int'(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bcd", {16'h0, bcd}, {16'h0, m_bcd});
    chk("ovf", {31'h0, ovf}, {31'h0, m_ovf});
    chk("an", {28'h0, an}, {28'h0, m_an});
    chk("seg", {25'h0, seg}, {25'h0, m_seg});
    chk("dp", {31'h0, dp}, 32'h1);
  endtask

  // One clock: predict the outputs after this edge, then compare at the falling edge.
  task automatic tick();
    logic [15:0] old;
    int sel, msd;
    @(posedge clk);
    k++;
    old = m_bcd;
    sel = ((k - 1) / RD) % 4;
    m_an = ~(4'b0001 << sel);
    m_seg = tbl[old[4*sel +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
    msd = 0;
    for (int i = 0; i < 4; i++) if (old[4*i +: 4] != 4'd0) msd = i;
    if (sel > msd) m_seg = 7'b1111111;
`else
    msd = 0;
`endif
    if ((k - 1) % 16 == 0) cap = val;
    if (k % 16 == 0) begin
      m_bcd = to_bcd(cap);
      m_ovf = (cap > 32'd9999);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input logic [31:0] v, input int n);
    val = v;
    repeat (n) tick();
  endtask

  task automatic model_reset();
    k = 0;
    m_bcd = 16'h0000;
    m_ovf = 1'b0;
    m_seg = 7'b1111111;
    m_an  = 4'b1111;
  endtask

  initial begin
    rst_n = 1'b0;
    val = 32'd0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    run(32'd0, 40);
    chk("zero_bcd", {16'h0, bcd}, 32'h0000);

    run(32'd1234, 40);
    chk("b1234", {16'h0, bcd}, 32'h1234);

    run(32'd9999, 33);
    chk("b9999", {16'h0, bcd}, 32'h9999);
    chk("o9999", {31'h0, ovf}, 32'h0);
    run(32'd10000, 33);
    chk("b10000", {16'h0, bcd}, 32'h9999);
    chk("o10000", {31'h0, ovf}, 32'h1);
    run(32'hFFFFFFFF, 33);
    chk("bmax", {16'h0, bcd}, 32'h9999);
    chk("omax", {31'h0, ovf}, 32'h1);

    run(32'd42, 40);
    run(32'd7, 40);

    // Value change right after the capture edge must not affect that conversion.
    while (k % 16 != 0) tick();
    val = 32'd5678;
    tick();
    val = 32'd4321;
    repeat (15) tick();
    chk("load5678", {16'h0, bcd}, 32'h5678);
    repeat (16) tick();
    chk("load4321", {16'h0, bcd}, 32'h4321);

    // Reset in the middle of a conversion.
    while (k % 16 != 0) tick();
    val = 32'd8888;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) tick();
    chk("rst_b15", {16'h0, bcd}, 32'h0000);
    tick();
    chk("rst_b16", {16'h0, bcd}, 32'h8888);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] v;
      case (i % 4)
        0: v = $urandom;
        1: v = $urandom_range(0, 9999);
        2: v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 120);
      endcase
      run(v, $urandom_range(10, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
